// File: rtl/vga_pkg.sv
// Shared raster timing constants for the 640x480@60 VGA path.
// vga_handler and the renderers import these so coordinate bounds and
// the renderer-to-DAC latency stay in step with the sync generator.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Level driven on hsync/vsync while the pulse is active (0 = active-low).
    localparam logic SYNC_POL = 1'b0;

    // Clocks from x/y to pixel_color in vga_handler (renderer reg + output reg).
    localparam int PIPE_DLY = 2;

    // Width of the x/y coordinate buses.
    localparam int CNT_W = 10;

    // Raw per-pixel decode carried down the delay line.
    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } sync_bits_t;

endpackage

// File: rtl/sync_delay_line.sv
// N-stage, W-bit shift register with asynchronous active-low clear.
// N = 0 degenerates to a plain wire from d to q.
module sync_delay_line #(
    parameter int W = 3,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (N == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n};
        assign q = d;
    end else begin : g_stages
        logic [W-1:0] stages [N];

        // Shift d through N stages; reset clears every stage to zero.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    stages[i] <= '0;
                end
            end else begin
                stages[0] <= d;
                for (int i = 1; i < N; i++) begin
                    stages[i] <= stages[i-1];
                end
            end
        end

        assign q = stages[N-1];
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: free-running pixel/line counters exposed as
// x/y, sync/blank strobes delayed to line up with the registered pixel
// colour downstream, and a once-per-frame tick at the start of vertical
// blanking that game logic uses as its safe update window.
module vga_sync_gen
#(
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter logic SYNC_POL = vga_pkg::SYNC_POL,
    parameter int   PIPE_DLY = vga_pkg::PIPE_DLY
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       frame_tick
);

    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOT > 1024) begin : g_h_total_check
        $error("vga_sync_gen: horizontal total exceeds the 10-bit counter range");
    end
    if (V_TOT > 1024) begin : g_v_total_check
        $error("vga_sync_gen: vertical total exceeds the 10-bit counter range");
    end

    // Terminal counts and decode bounds; the window ends are 11 bits wide
    // so a total of exactly 1024 cannot alias back to zero.
    localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
    localparam logic [10:0] H_VIS_E  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS_E  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    sync_bits_t raw_nxt;
    sync_bits_t raw;
    sync_bits_t dly;

    // Next raster position; line and frame wrap resolve on the same edge.
    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            if (v_cnt == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = v_cnt + 10'd1;
            end
        end
    end

    // Decode the upcoming position so the registered strobes sit in the
    // same cycle as the coordinates they describe (zero added latency).
    always_comb begin
        raw_nxt     = '0;
        raw_nxt.vis = ({1'b0, h_nxt} < H_VIS_E) && ({1'b0, v_nxt} < V_VIS_E);
        raw_nxt.hs  = ({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END);
        raw_nxt.vs  = ({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END);
    end

    // Counters, aligned decode and the start-of-vblank tick.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            raw        <= '0;
            frame_tick <= 1'b0;
        end else begin
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            raw        <= raw_nxt;
            frame_tick <= (h_nxt == 10'd0) && (v_nxt == V_VIS);
        end
    end

    sync_delay_line #(
        .W (3),
        .N (PIPE_DLY)
    ) u_delay (
        .clk   (vga_clk),
        .rst_n (rst_n),
        .d     (raw),
        .q     (dly)
    );

    assign x = h_cnt;
    assign y = v_cnt;

    // Polarity is a constant, so these reduce to a wire or an inverter on a
    // flop output and cannot glitch.
    assign hsync   = dly.hs ? SYNC_POL : ~SYNC_POL;
    assign vsync   = dly.vs ? SYNC_POL : ~SYNC_POL;
    assign blank_n = dly.vis;

endmodule
